// File: rtl/f3_dot_seq.sv
// GF(3) dot-product sequencer: one element per clock through a shared multiply/accumulate unit.
// Start/busy/done handshake; result C holds until the next done pulse.
module f3_dot_seq #(
   parameter int unsigned LEN = 8,
   parameter int unsigned CW  = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               sub,
   input  logic [2*LEN-1:0]   A,
   input  logic [2*LEN-1:0]   B,
   output logic               busy,
   output logic               done,
   output logic [1:0]         C
);

   localparam int unsigned VW = 2 * LEN;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam logic [CW-1:0] LAST = CW'(LEN - 1);

   logic [0:0]    state_q, state_d;
   logic [VW-1:0] a_q, a_d, b_q, b_d;
   logic          sub_q, sub_d;
   logic [1:0]    acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_d, done_d;
   logic [1:0]    c_d;
   logic [1:0]    prod, term, acc_upd;

   // Codes 11 and 00 both act as zero; equal nonzero operands give 1, unequal give 2.
   function automatic logic [1:0] gf3_mul(input logic [1:0] x, input logic [1:0] y);
      if (x == 2'b00 || y == 2'b00 || x == 2'b11 || y == 2'b11) return 2'b00;
      else if (x == y) return 2'b01;
      else return 2'b10;
   endfunction

   // Operands are always valid codes here, so the code value equals the field value.
   function automatic logic [1:0] gf3_add(input logic [1:0] x, input logic [1:0] y);
      logic [2:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

   assign prod    = gf3_mul(a_q[1:0], b_q[1:0]);
   assign term    = sub_q ? {prod[0], prod[1]} : prod;
   assign acc_upd = gf3_add(acc_q, term);

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      busy_d  = busy;
      done_d  = 1'b0;
      c_d     = C;
      case (state_q)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               a_d     = A;
               b_d     = B;
               sub_d   = sub;
               acc_d   = 2'b00;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            acc_d = acc_upd;
            a_d   = a_q >> 2;
            b_d   = b_q >> 2;
            if (cnt_q == LAST) begin
               c_d     = acc_upd;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         acc_q   <= 2'b00;
         cnt_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         C       <= 2'b00;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         busy    <= busy_d;
         done    <= done_d;
         C       <= c_d;
      end
   end

endmodule

// File: doc/f3_dot_seq.md
Name: f3_dot_seq

Overview:
- Sequencer that computes a GF(3) dot product (or negated dot product) of two packed LEN-element vectors.
- Processes one element per clock through a single GF(3) multiplier and a single GF(3) adder/subtractor.
- Start/busy/done handshake, so a higher-level pairing controller can share one small arithmetic unit across long vectors instead of instantiating LEN multipliers.
- GF(3) element encoding, 2 bits {hi,lo}: 0=2'b00, 1=2'b01, 2=2'b10; 2'b11 is invalid and is treated as 0.

Parameters:
- LEN, 8, number of GF(3) elements per operand vector; legal range 2..64.
- CW, 7, counter width; must satisfy 2^CW > LEN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when idle (busy=0).
- sub  input  1  latched with start; 0: result = sum(A[i]*B[i]); 1: result = -sum(A[i]*B[i]).
- A  input  2*LEN  operand vector; element i = A[2i+1:2i]; element 0 is at the LSBs.
- B  input  2*LEN  operand vector, same packing as A.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when C becomes valid.
- C  output  2  GF(3) result; holds its value until the next done.

Behaviour:
- Clock and reset: single clock, clk; reset is synchronous and active-high.
- Reset: on any clk edge with reset=1, go to IDLE; busy=0, done=0, C=2'b00, accumulator=0, counter=0. This applies mid-operation: the operation is abandoned and no done is produced. Reset has priority over start.
- States: IDLE, RUN.
- IDLE, start=1 at edge k:
  - latch A, B, sub into internal shift registers;
  - clear accumulator and counter;
  - next state RUN; busy=1 after edge k.
- RUN, edges k+1 .. k+LEN:
  - p = mult(Aelem0, Belem0);
  - acc <= sub ? acc - p : acc + p (mod 3);
  - shift both operand registers right by 2 bits; counter++.
- Last element (counter = LEN-1):
  - C <= updated acc; done=1 for exactly one cycle; busy=0; next state IDLE.
  - done and C are therefore visible after edge k+LEN. Latency is LEN cycles from the start sample to done.
- start while busy=1: ignored, with no effect on the operands or the accumulator.
- start=1 in the cycle where done=1: accepted, since the block is already IDLE (busy=0). Back-to-back throughput is one operation per LEN+1 cycles.
- A and B may change freely after the start edge.
- Arithmetic (GF(3), no carries):
  - mult: 1*1=1, 1*2=2, 2*2=1, anything*0=0; any operand element 2'b11 yields product 2'b00.
  - add/sub: mod 3, producing only the codes 00, 01, 10.
  - The accumulator must never hold 2'b11; C is never 2'b11.
- Negation of a GF(3) value swaps its hi and lo bits.
- Counter: counts 0..LEN-1 and does not wrap during RUN; it is cleared on entry to RUN.
- done is never asserted while busy=1, and busy is never asserted in the same cycle as done.

Test Plan:
- Basic sum: LEN=4, A=8'h19 (elements [1,2,1,0]), B=8'hA5 (elements [1,1,2,2]), sub=0, start for 1 cycle -> busy high for 4 cycles; done pulses 4 cycles after the start edge; C=2'b10 (1+2+2+0=5≡2).
- Negated sum: same operands with sub=1 -> C=2'b01 (-5≡1). Same latency.
- Invalid codes and zero: A=8'hFF (all 11), B=8'h55 -> C=2'b00. Then A=8'h55, B=8'h55 (four 1*1 products) -> C=2'b01 (4≡1). No 2'b11 ever appears on C.
- Start during busy: pulse start again at cycle k+2 with different operands -> ignored; C=2'b10 at the original done; busy stays low afterwards with no second done.
- Back-to-back and mid-operation reset:
  - hold start=1 continuously -> a new operation is accepted in each done cycle, with done every 5 cycles (LEN=4).
  - assert reset at cycle k+2 -> busy=0, C=2'b00, and no done pulse follows.
  - a subsequent start produces the correct result.
- Randomized: 1000 random operand pairs with LEN=8 (element codes include 11), compared against a mod-3 reference model -> C and the done timing match on every operation.
